aes_unmask: RTL

- Receiving-end counterpart of the AES masking block.
- Regenerates the keyed, rotating mask stream and strips it from a masked 128-bit block, returning the plain block for the AES datapath.
- Keeps a per-block evolving key state. Masker and unmasker stay in lock-step only if both see the same init/next sequence.

---
 rtl/aes_unmask_if.sv | 40 ++++
 rtl/aes_unmask.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/aes_unmask_if.sv
// ---------------------------------------------------------------------------
// aes_unmask_if
// Bundles the command/data signals of the AES unmasking block.
//
// Handshake: init and next are single-cycle commands. They are taken only on
// a rising clock edge where ready=1; while ready=0 they are ignored and never
// queued. If both are high on an accepting edge, init wins and next is lost.
// result_valid rises on the same edge as ready and stays high until the next
// accepted command or reset.
//
// Signals:
//   init, next    command pulses (master -> slave)
//   key, keylen   mask key and schedule select, sampled with init
//   block         masked 128-bit block, sampled with next
//   result        unmasked block (slave -> master)
//   ready         slave idle and able to take a command
//   result_valid  result holds the unmasked value of the last next
//   dbg_state     current FSM state of the slave, for observation only
// ---------------------------------------------------------------------------
interface aes_unmask_if;
  logic         init;
  logic         next;
  logic [127:0] key;
  logic         keylen;
  logic [127:0] block;
  logic [127:0] result;
  logic         ready;
  logic         result_valid;
  logic [1:0]   dbg_state;

  modport master (
    output init, next, key, keylen, block,
    input  result, ready, result_valid, dbg_state
  );

  modport slave (
    input  init, next, key, keylen, block,
    output result, ready, result_valid, dbg_state
  );
endinterface

// File: rtl/aes_unmask.sv
// ---------------------------------------------------------------------------
// aes_unmask
// Receiving-end counterpart of the AES masking block. Regenerates the keyed,
// rotating mask stream and strips it from a masked 128-bit block.
//
// For each block, with key state S, schedule length N and rotate amount R:
//   mask = XOR_{i=0..N-1} rotr^i(S)
// After each block the key state evolves to rotr^N(S) ^ key, so masker and
// unmasker stay aligned only when both see the same init/next sequence.
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      aes_unmask_if.slave (init/next/key/keylen/block in,
//            result/ready/result_valid/dbg_state out)
//
// Timing: init keeps ready low for 1 cycle; next keeps it low for N+1 cycles
// (N ROUND cycles plus one FINAL cycle).
// ---------------------------------------------------------------------------
module aes_unmask #(
  parameter int ROUNDS_SHORT = 10,
  parameter int ROUNDS_LONG  = 14,
  parameter int ROT_SHORT    = 19,
  parameter int ROT_LONG     = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  aes_unmask_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_SHORT = 4'(ROUNDS_SHORT - 1);
  localparam logic [3:0] LAST_LONG  = 4'(ROUNDS_LONG - 1);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] key_q, key_d;
  logic         keylen_q, keylen_d;
  logic [127:0] s_q, s_d;          // evolving key state
  logic [127:0] rk_q, rk_d;        // rotating round key within one block
  logic [127:0] state_q, state_d;  // working block, also the result
  logic [3:0]   ctr_q, ctr_d;
  logic         valid_q, valid_d;

  logic [127:0] rk_rot;
  logic [3:0]   ctr_last;

  // Both rotations are fixed wiring; keylen_q only picks which one is used.
  always_comb begin
    if (keylen_q) begin
      rk_rot   = {rk_q[ROT_LONG-1:0], rk_q[127:ROT_LONG]};
      ctr_last = LAST_LONG;
    end else begin
      rk_rot   = {rk_q[ROT_SHORT-1:0], rk_q[127:ROT_SHORT]};
      ctr_last = LAST_SHORT;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      key_q    <= '0;
      keylen_q <= 1'b0;
      s_q      <= '0;
      rk_q     <= '0;
      state_q  <= '0;
      ctr_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      key_q    <= key_d;
      keylen_q <= keylen_d;
      s_q      <= s_d;
      rk_q     <= rk_d;
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    fsm_d    = fsm_q;
    key_d    = key_q;
    keylen_d = keylen_q;
    s_d      = s_q;
    rk_d     = rk_q;
    state_d  = state_q;
    ctr_d    = ctr_q;
    valid_d  = valid_q;

    case (fsm_q)
      IDLE: begin
        if (bus.init) begin
          // init wins over a simultaneous next; the next is dropped.
          key_d    = bus.key;
          keylen_d = bus.keylen;
          s_d      = bus.key;
          valid_d  = 1'b0;
          fsm_d    = INIT;
        end else if (bus.next) begin
          state_d = bus.block;
          rk_d    = s_q;
          ctr_d   = '0;
          valid_d = 1'b0;
          fsm_d   = ROUND;
        end
      end

      INIT: begin
        fsm_d = IDLE;
      end

      ROUND: begin
        state_d = state_q ^ rk_q;
        rk_d    = rk_rot;
        ctr_d   = ctr_q + 4'd1;
        if (ctr_q == ctr_last) begin
          fsm_d = FINAL;
        end
      end

      FINAL: begin
        // rk_q has been rotated N times from the starting key state here.
        s_d     = rk_q ^ key_q;
        valid_d = 1'b1;
        fsm_d   = IDLE;
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign bus.result       = state_q;
  assign bus.ready        = (fsm_q == IDLE);
  assign bus.result_valid = valid_q;
  assign bus.dbg_state    = fsm_q;

endmodule
